// File: rtl/preamble_framer_if.sv
// Streaming bus between the framer and its neighbours: payload in, framed words out.
// Latency: none, wires only.
// Backpressure: valid/ready on both directions; the slave side is the framer.
interface preamble_framer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] signal_in;
   logic                  valid_in;
   logic                  ready_out;
   logic [DATA_WIDTH-1:0] signal_out;
   logic                  valid_out;
   logic                  ready_in;
   logic                  preamble_flag;
   logic                  last_out;

   modport slave (
      input  signal_in, valid_in, ready_in,
      output ready_out, signal_out, valid_out, preamble_flag, last_out
   );

   modport master (
      output signal_in, valid_in, ready_in,
      input  ready_out, signal_out, valid_out, preamble_flag, last_out
   );
endinterface

// File: rtl/preamble_framer.sv
// Prefixes each frame of payload words with a configurable constant or incrementing preamble.
// Latency: one cycle from an accepted payload word to signal_out; one IDLE cycle between frames.
// Backpressure: single output register that loads only when empty or being drained; ready_out follows it in DATA.
module preamble_framer #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   preamble_framer_if.slave      bus,
   input  logic [DATA_WIDTH-1:0] preamble_value,
   input  logic [LEN_WIDTH-1:0]  preamble_length,
   input  logic [LEN_WIDTH-1:0]  frame_length,
   input  logic                  mode,
   output logic [31:0]           frame_count,
   output logic                  error
);

   typedef enum logic [1:0] {IDLE, PRE, DATA, ERR} state_t;

   state_t                state, state_nx;

   // Configuration captured when a frame starts, so the inputs may change mid-frame.
   logic [DATA_WIDTH-1:0] pv_q;
   logic [LEN_WIDTH-1:0]  pl_q;
   logic [LEN_WIDTH-1:0]  fl_q;
   logic                  mode_q;

   logic [LEN_WIDTH-1:0]  pre_cnt;
   logic [LEN_WIDTH-1:0]  dat_cnt;

   logic [DATA_WIDTH-1:0] out_dat;
   logic                  out_vld;
   logic                  out_pre;
   logic                  out_last;

   logic                  out_free;
   logic                  ready_o;
   logic                  latch_cfg;
   logic                  ld_pre;
   logic                  ld_dat;
   logic                  pre_done;
   logic                  last_word;
   logic [DATA_WIDTH-1:0] pre_word;

   assign out_free = !out_vld || bus.ready_in;
   assign pre_word = mode_q ? (pv_q + DATA_WIDTH'(pre_cnt)) : pv_q;

   assign bus.ready_out     = ready_o;
   assign bus.signal_out    = out_dat;
   assign bus.valid_out     = out_vld;
   assign bus.preamble_flag = out_pre;
   assign bus.last_out      = out_last;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_nx  = state;
      ready_o   = 1'b0;
      latch_cfg = 1'b0;
      ld_pre    = 1'b0;
      ld_dat    = 1'b0;
      pre_done  = 1'b0;
      last_word = 1'b0;
      case (state)
         IDLE: begin
            if (bus.valid_in) begin
               latch_cfg = 1'b1;
               if (frame_length == '0)         state_nx = ERR;
               else if (preamble_length == '0) state_nx = DATA;
               else                            state_nx = PRE;
            end
         end
         PRE: begin
            if (out_free) begin
               ld_pre = 1'b1;
               if (pre_cnt == pl_q - LEN_WIDTH'(1)) begin
                  pre_done = 1'b1;
                  state_nx = DATA;
               end
            end
         end
         DATA: begin
            ready_o = out_free;
            if (bus.valid_in && out_free) begin
               ld_dat = 1'b1;
               if (dat_cnt == fl_q - LEN_WIDTH'(1)) begin
                  last_word = 1'b1;
                  state_nx  = IDLE;
               end
            end
         end
         ERR: begin
            state_nx = ERR;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Capture frame configuration on leaving IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q   <= '0;
         pl_q   <= '0;
         fl_q   <= '0;
         mode_q <= 1'b0;
      end else if (latch_cfg) begin
         pv_q   <= preamble_value;
         pl_q   <= preamble_length;
         fl_q   <= frame_length;
         mode_q <= mode;
      end
   end

   // Word counters within the preamble and payload phases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         dat_cnt <= '0;
      end else begin
         if (ld_pre) pre_cnt <= pre_done ? '0 : pre_cnt + LEN_WIDTH'(1);
         if (ld_dat) dat_cnt <= last_word ? '0 : dat_cnt + LEN_WIDTH'(1);
      end
   end

   // Output register: loads a preamble or payload word, otherwise empties when drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_dat  <= '0;
         out_vld  <= 1'b0;
         out_pre  <= 1'b0;
         out_last <= 1'b0;
      end else if (ld_pre) begin
         out_dat  <= pre_word;
         out_vld  <= 1'b1;
         out_pre  <= 1'b1;
         out_last <= 1'b0;
      end else if (ld_dat) begin
         out_dat  <= bus.signal_in;
         out_vld  <= 1'b1;
         out_pre  <= 1'b0;
         out_last <= last_word;
      end else if (bus.ready_in) begin
         out_vld  <= 1'b0;
      end
   end

   // Completed-frame counter and sticky configuration error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count <= '0;
         error       <= 1'b0;
      end else begin
         if (ld_dat && last_word) frame_count <= frame_count + 32'd1;
         if (state_nx == ERR)     error       <= 1'b1;
      end
   end

endmodule

// File: doc/preamble_framer.md
PREAMBLE_FRAMER -- requirements
Module: preamble_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of data words in and out.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 32, the width of the length inputs and internal counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port signal_in, input, DATA_WIDTH bits: payload word.
REQ-006 The block SHALL have port valid_in, input, 1 bit: signal_in is valid.
REQ-007 The block SHALL have port ready_out, output, 1 bit: the block accepts signal_in this cycle.
REQ-008 The block SHALL have port signal_out, output, DATA_WIDTH bits: framed output word.
REQ-009 The block SHALL have port valid_out, output, 1 bit: signal_out is valid.
REQ-010 The block SHALL have port ready_in, input, 1 bit: downstream accepts signal_out.
REQ-011 The block SHALL have port preamble_value, input, DATA_WIDTH bits: base preamble word.
REQ-012 The block SHALL have port preamble_length, input, LEN_WIDTH bits: number of preamble words per frame.
REQ-013 The block SHALL have port frame_length, input, LEN_WIDTH bits: number of payload words per frame.
REQ-014 The block SHALL have port mode, input, 1 bit: 0 = constant preamble; 1 = incrementing preamble (preamble_value+i).
REQ-015 The block SHALL have port preamble_flag, output, 1 bit: the current signal_out word is a preamble word.
REQ-016 The block SHALL have port last_out, output, 1 bit: the current signal_out word is the last payload word of a frame.
REQ-017 The block SHALL have port frame_count, output, 32 bits: number of completed frames, which wraps modulo 2^32.
REQ-018 The block SHALL have port error, output, 1 bit: sticky configuration error.

Function
REQ-019 Handshakes: a transfer SHALL occur when valid and ready are both high at a clock edge; once valid_out is high, signal_out, preamble_flag and last_out SHALL hold stable until ready_in.
REQ-020 Output register: it SHALL load only when (!valid_out || ready_in), and SHALL clear valid_out when ready_in is high and nothing new is loaded.
REQ-021 FSM states SHALL be IDLE, PRE, DATA and ERR.
REQ-022 In IDLE, valid_in high SHALL latch preamble_value, preamble_length, frame_length and mode; those inputs SHALL be ignored until the next IDLE exit.
REQ-023 From IDLE, a latched frame_length of 0 SHALL go to ERR, a latched preamble_length of 0 SHALL go to DATA, and all other cases SHALL go to PRE.
REQ-024 PRE SHALL emit exactly preamble_length words, one per output-register load, with word i (0-based) equal to preamble_value when mode=0 and to preamble_value+i (mod 2^DATA_WIDTH) when mode=1; preamble_flag=1.
REQ-025 PRE SHALL hold ready_out=0 and SHALL go to DATA after the last preamble word loads.
REQ-026 DATA SHALL drive ready_out = (!valid_out || ready_in); each accepted word SHALL appear on signal_out the next cycle (latency 1); preamble_flag=0.
REQ-027 DATA SHALL pass exactly frame_length words; the last one SHALL carry last_out=1, SHALL increment frame_count on its load, and SHALL return the FSM to IDLE.
REQ-028 A back-to-back frame SHALL NOT need idle gap beyond the single IDLE cycle.
REQ-029 ERR SHALL set error=1 and hold ready_out=0, and the output register SHALL drain normally; ERR SHALL be exited only by rst.
REQ-030 ready_out SHALL be 0 in IDLE, PRE and ERR; valid_in dropping mid-DATA SHALL stall without losing count.
REQ-031 Counters SHALL be LEN_WIDTH wide, with compare-to-length-minus-one termination; the maximum length 2^LEN_WIDTH-1 SHALL be legal.

Reset
REQ-032 On rst high, the block SHALL go asynchronously to IDLE with valid_out=0, ready_out=0, signal_out=0, preamble_flag=0, last_out=0, frame_count=0, error=0 and counters=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, the next frame SHALL start with a full preamble.

Verification
REQ-034 The bench SHALL cover: mode=0, preamble_value=23, preamble_length=5, frame_length=16, signal_in=1,2,3... with valid_in=1 and ready_in=1 -> 23 x5 (flag=1), then 1..16 with last_out on 16, then 23 x5 and 17..32; frame_count=2.
REQ-035 The bench SHALL cover: the same configuration with ready_in toggling 1,0 every cycle -> identical word sequence, outputs stable while stalled, no drops or duplicates.
REQ-036 The bench SHALL cover: mode=1, preamble_value=0xA0, preamble_length=3, frame_length=4 -> A0,A1,A2 then four payload words.
REQ-037 The bench SHALL cover: preamble_length=0, frame_length=2 -> payload-only frames, preamble_flag never set.
REQ-038 The bench SHALL cover: frame_length=0 with valid_in=1 -> error=1 on the next cycle, ready_out stuck at 0; after rst, error=0.
REQ-039 The bench SHALL cover: rst asserted after 8 payload words -> outputs clear immediately; after release, output restarts with 23 x5.
